reg_file_dump_reader: RTL and testbench
=======================================

Name: reg_file_dump_reader

Overview:
- Hardware read-out engine for the MIPS register file; the reading end of the register file.
- On a start pulse it walks a programmable address range through one register file read port. Each unmasked register goes out as an (addr, data) beat on a valid/ready stream to the debug/trace sink.
- Replaces per-cycle simulation printouts with a synthesizable, back-pressurable dump.
- Sits beside the decode-stage read ports. It shares a read port only while the core is halted, and external muxing handles that sharing.

Parameters:
- ADDR_SIZE, 5, register address width.
- WORD, 32, register data width.
- FIRST_ADDR, 0, first address scanned (inclusive).
- LAST_ADDR, 31, last address scanned (inclusive); FIRST_ADDR <= LAST_ADDR <= 2**ADDR_SIZE-1.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request to begin a dump.
- skip_mask  input  2**ADDR_SIZE  bit n = 1 means skip register n; latched on accepted start.
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle pulse after the final beat, or after the scan when every register was skipped.
- rf_read_addr  output  ADDR_SIZE  address to the register file read port.
- rf_read_data  input  WORD  combinational read data returned for rf_read_addr.
- dump_valid  output  1  beat valid.
- dump_ready  input  1  sink accepts the beat.
- dump_addr  output  ADDR_SIZE  register number of the beat.
- dump_data  output  WORD  register value of the beat.
- dump_last  output  1  high with the final beat of a dump.

Behaviour:
- Reset: rst_n low at a rising edge sets the following, with or without a dump in progress:
  - state = IDLE;
  - busy = 0, done = 0, dump_valid = 0, dump_last = 0;
  - dump_addr = 0, dump_data = 0, rf_read_addr = 0, cursor = 0, mask register = 0.
- States: IDLE, CHECK, SEND, DONE.
- IDLE:
  - rf_read_addr = 0.
  - start = 1 causes: mask register <= skip_mask; cursor <= FIRST_ADDR; next state CHECK.
- CHECK:
  - rf_read_addr = cursor.
  - If mask[cursor] = 0, at the edge: dump_data <= rf_read_data; dump_addr <= cursor; dump_last <= (no unmasked address in (cursor, LAST_ADDR]); next state SEND.
  - If mask[cursor] = 1 and cursor == LAST_ADDR, next state is DONE. Otherwise cursor increments and the state stays CHECK.
  - Rate: one address per cycle.
- SEND:
  - dump_valid = 1.
  - dump_addr, dump_data and dump_last stay stable until dump_valid && dump_ready.
  - On handshake: if dump_last, next state is DONE; else cursor increments and the next state is CHECK.
  - dump_ready is never required to be high.
- DONE: done = 1 for exactly one cycle, then IDLE.
- Latency and rate:
  - start sampled at edge k leads to dump_valid high after edge k+1 when FIRST_ADDR is unmasked.
  - Throughput with dump_ready held high: 2 cycles per beat.
  - A full 32-register dump takes 64 cycles, plus 1 for DONE.
- Start handling: start while busy is ignored. start is a level sampled only in IDLE, so a held start re-triggers a dump after DONE.
- Coherence:
  - Each register is sampled at the rising edge that leaves CHECK, so it reflects any register-file write completed on the preceding falling edge.
  - Writes landing during SEND are not reflected in that beat.
  - The dump is not atomic across registers.
- Data rules:
  - Register 0 is dumped as whatever the port returns; no forcing.
  - Cursor never wraps: it stops at LAST_ADDR, and when LAST_ADDR = 2**ADDR_SIZE-1 the increment is never taken.
- All skipped: no beats are sent; done pulses (LAST_ADDR-FIRST_ADDR+2) cycles after start is sampled.
- dump_last: computed from the latched mask, never from the live skip_mask input.

Decomposition:
- Package reg_dump_pkg holds:
  - the state enumeration (IDLE, CHECK, SEND, DONE);
  - default ADDR_SIZE/WORD constants;
  - the beat field widths.
- Sub-module reg_dump_last_detect is combinational.
  - Inputs: latched mask, cursor.
  - Output: the "no unmasked address above cursor up to LAST_ADDR" flag.
  - Purpose: keeps the range-reduction logic isolated and unit-testable.

Test Plan:
- Full dump, ready tied high:
  - Stimulus: register n preloaded with 32'hA000_0000+n; mask 0; start.
  - Required response: 32 beats, addr 0..31, data A0000000..A000001F; dump_last only on addr 31; done 1 cycle after the last handshake; total 65 cycles.
- Sparse mask with back-pressure:
  - Stimulus: mask = ~(bit8|bit16|bit25); dump_ready low for 3 cycles on each beat.
  - Required response: beats for addrs 8, 16, 25 only; fields stable while stalled; dump_last on 25.
- All masked:
  - Stimulus: mask = 32'hFFFF_FFFF; start.
  - Required response: zero beats; done pulses at cycle 33 after start; busy low next cycle.
- Start while busy:
  - Stimulus: second start pulse mid-dump.
  - Required response: ignored; exactly one done; beat count unchanged.
- Reset mid-dump:
  - Stimulus: rst_n low during SEND of addr 5 (valid high, ready low).
  - Required response: after that edge dump_valid=0, busy=0, state IDLE; a new start begins again at FIRST_ADDR.
- Write during dump:
  - Stimulus: a register-file write of 32'hDEAD_BEEF to reg 20 on the falling edge before CHECK reaches 20.
  - Required response: beat 20 carries DEADBEEF.

Source files
------------

// File: rtl/reg_dump_pkg.sv
// Shared definitions for the register file dump reader.
// Holds the engine state encoding, the default register-file geometry and the
// widths of the fields carried by one dump beat.
package reg_dump_pkg;

    // Default register-file geometry (MIPS: 32 x 32-bit).
    localparam int unsigned DefAddrSize = 5;
    localparam int unsigned DefWord     = 32;

    // Beat field widths on the dump stream: register number and register value.
    localparam int unsigned BeatAddrWidth = DefAddrSize;
    localparam int unsigned BeatDataWidth = DefWord;

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StSend,
        StDone
    } dump_state_e;

endpackage

// File: rtl/reg_dump_last_detect.sv
// Combinational "is this the final beat" detector for the dump reader.
// Ports:
//   mask       - latched skip mask, bit n = 1 means register n is skipped
//   cursor     - address currently being examined
//   none_above - 1 when no unmasked address exists in (cursor, LAST_ADDR]
module reg_dump_last_detect #(
    parameter int unsigned ADDR_SIZE = reg_dump_pkg::DefAddrSize,
    parameter int unsigned LAST_ADDR = 31
) (
    input  logic [2**ADDR_SIZE-1:0] mask,
    input  logic [ADDR_SIZE-1:0]    cursor,
    output logic                    none_above
);

    always_comb begin
        none_above = 1'b1;
        for (int i = 0; i <= int'(LAST_ADDR); i++) begin
            if ((i > int'(cursor)) && !mask[i[ADDR_SIZE-1:0]]) begin
                none_above = 1'b0;
            end
        end
    end

endmodule

// File: rtl/reg_file_dump_reader.sv
// Register file dump reader: on start, walks FIRST_ADDR..LAST_ADDR through one
// register-file read port and emits each unmasked register as an (addr, data)
// beat on a valid/ready stream.
// Ports:
//   clk, rst_n             - clock, synchronous active-low reset
//   start, skip_mask       - dump request and per-register skip mask (latched on start)
//   busy, done             - engine active / one-cycle completion pulse
//   rf_read_addr/data      - register file read port (data is combinational)
//   dump_valid/ready       - beat handshake
//   dump_addr/data/last    - beat payload; last marks the final beat of a dump
module reg_file_dump_reader
    import reg_dump_pkg::*;
#(
    parameter int unsigned ADDR_SIZE  = DefAddrSize,
    parameter int unsigned WORD       = DefWord,
    parameter int unsigned FIRST_ADDR = 0,
    parameter int unsigned LAST_ADDR  = 31
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [2**ADDR_SIZE-1:0] skip_mask,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_SIZE-1:0]    rf_read_addr,
    input  logic [WORD-1:0]         rf_read_data,
    output logic                    dump_valid,
    input  logic                    dump_ready,
    output logic [ADDR_SIZE-1:0]    dump_addr,
    output logic [WORD-1:0]         dump_data,
    output logic                    dump_last
);

    localparam logic [ADDR_SIZE-1:0] FirstAddr = ADDR_SIZE'(FIRST_ADDR);
    localparam logic [ADDR_SIZE-1:0] LastAddr  = ADDR_SIZE'(LAST_ADDR);
    localparam logic [ADDR_SIZE-1:0] AddrOne   = ADDR_SIZE'(1);

    dump_state_e             state_q, state_d;
    logic [ADDR_SIZE-1:0]    cursor_q, cursor_d;
    logic [2**ADDR_SIZE-1:0] mask_q, mask_d;
    logic [ADDR_SIZE-1:0]    addr_q, addr_d;
    logic [WORD-1:0]         data_q, data_d;
    logic                    last_q, last_d;
    logic                    none_above;

    // Uses the latched mask so a changing skip_mask input cannot disturb dump_last.
    reg_dump_last_detect #(
        .ADDR_SIZE (ADDR_SIZE),
        .LAST_ADDR (LAST_ADDR)
    ) u_last_detect (
        .mask       (mask_q),
        .cursor     (cursor_q),
        .none_above (none_above)
    );

    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        mask_d   = mask_q;
        addr_d   = addr_q;
        data_d   = data_q;
        last_d   = last_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    mask_d   = skip_mask;
                    cursor_d = FirstAddr;
                    state_d  = StCheck;
                end
            end
            StCheck: begin
                if (!mask_q[cursor_q]) begin
                    // Register sampled here; later writes do not reach this beat.
                    data_d  = rf_read_data;
                    addr_d  = cursor_q;
                    last_d  = none_above;
                    state_d = StSend;
                end else if (cursor_q == LastAddr) begin
                    state_d = StDone;
                end else begin
                    cursor_d = cursor_q + AddrOne;
                end
            end
            StSend: begin
                if (dump_ready) begin
                    if (last_q) begin
                        state_d = StDone;
                    end else begin
                        // An unmasked address remains above, so cursor < LAST_ADDR.
                        cursor_d = cursor_q + AddrOne;
                        state_d  = StCheck;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cursor_q <= '0;
            mask_q   <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            mask_q   <= mask_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            last_q   <= last_d;
        end
    end

    assign busy         = (state_q != StIdle);
    assign done         = (state_q == StDone);
    assign dump_valid   = (state_q == StSend);
    assign rf_read_addr = (state_q == StCheck) ? cursor_q : '0;
    assign dump_addr    = addr_q;
    assign dump_data    = data_q;
    assign dump_last    = last_q;

endmodule

// File: tb/tb_reg_file_dump_reader.sv
// Self-checking bench for reg_file_dump_reader: scoreboard of expected beats,
// register file model, back-pressure generator and timing checks.
module tb_reg_file_dump_reader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] skip_mask;
    logic        busy;
    logic        done;
    logic [4:0]  rf_read_addr;
    logic [31:0] rf_read_data;
    logic        dump_valid;
    logic        dump_ready;
    logic [4:0]  dump_addr;
    logic [31:0] dump_data;
    logic        dump_last;

    logic [31:0] rf [32];
    assign rf_read_data = rf[rf_read_addr];

    reg_file_dump_reader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .skip_mask    (skip_mask),
        .busy         (busy),
        .done         (done),
        .rf_read_addr (rf_read_addr),
        .rf_read_data (rf_read_data),
        .dump_valid   (dump_valid),
        .dump_ready   (dump_ready),
        .dump_addr    (dump_addr),
        .dump_data    (dump_data),
        .dump_last    (dump_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    beat_cnt = 0;
    int    done_cnt = 0;
    int    ready_mode = 0;  // 0: tied high, 1: 3-cycle stall per beat, 2: held low

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Build the expected beat list from the current register model.
    task automatic push_expected(input logic [31:0] mask, input bit patch_en,
                                 input int patch_addr, input logic [31:0] patch_data);
        int hi;
        beat_t b;
        hi = -1;
        for (int n = 0; n < 32; n++) if (!mask[n]) hi = n;
        for (int n = 0; n < 32; n++) begin
            if (!mask[n]) begin
                b.addr = n[4:0];
                b.data = (patch_en && n == patch_addr) ? patch_data : rf[n];
                b.last = (n == hi);
                exp_q.push_back(b);
            end
        end
    endtask

    // Ready generator: inputs change 1 time unit after the rising edge.
    int stall_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (ready_mode == 0) begin
            dump_ready = 1'b1;
        end else if (ready_mode == 2) begin
            dump_ready = 1'b0;
        end else if (dump_valid) begin
            if (stall_cnt >= 3) begin
                dump_ready = 1'b1;
            end else begin
                dump_ready = 1'b0;
                stall_cnt++;
            end
        end else begin
            dump_ready = 1'b0;
            stall_cnt  = 0;
        end
    end

    // Monitor: samples on the falling edge what the next rising edge will see.
    logic        prev_stall = 1'b0;
    beat_t       held;
    always @(negedge clk) begin
        beat_t e;
        if (done) done_cnt++;
        if (dump_valid && prev_stall) begin
            check("stall_addr", 64'(dump_addr), 64'(held.addr));
            check("stall_data", 64'(dump_data), 64'(held.data));
            check("stall_last", 64'(dump_last), 64'(held.last));
        end
        if (dump_valid && dump_ready && rst_n) begin
            beat_cnt++;
            if (exp_q.size() == 0) begin
                check("beat_unexpected", 64'(dump_addr), 64'hFFFF);
            end else begin
                e = exp_q.pop_front();
                check("beat_addr", 64'(dump_addr), 64'(e.addr));
                check("beat_data", 64'(dump_data), 64'(e.data));
                check("beat_last", 64'(dump_last), 64'(e.last));
            end
        end
        prev_stall = dump_valid && !dump_ready && rst_n;
        held.addr  = dump_addr;
        held.data  = dump_data;
        held.last  = dump_last;
    end

    // Pulse start for one cycle; returns 1 time unit after the edge that sampled it.
    task automatic start_dump(input logic [31:0] m);
        @(posedge clk);
        #1;
        start     = 1'b1;
        skip_mask = m;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts falling edges (one per clock after the start edge) until done is seen.
    task automatic wait_done(output int edges);
        edges = 0;
        while (edges < 500) begin
            @(negedge clk);
            edges++;
            if (done) break;
        end
        if (edges >= 500) check("done_timeout", 64'(0), 64'(1));
    endtask

    initial begin
        int edges;
        int d0;
        int b0;
        rst_n      = 1'b0;
        start      = 1'b0;
        skip_mask  = '0;
        dump_ready = 1'b1;
        for (int n = 0; n < 32; n++) rf[n] = 32'hA000_0000 + n;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_valid", 64'(dump_valid), 64'(0));
        check("rst_last", 64'(dump_last), 64'(0));
        check("rst_addr", 64'(dump_addr), 64'(0));
        check("rst_data", 64'(dump_data), 64'(0));
        check("rst_rfaddr", 64'(rf_read_addr), 64'(0));
        rst_n = 1'b1;

        // Full dump, ready tied high.
        ready_mode = 0;
        d0 = done_cnt;
        b0 = beat_cnt;
        push_expected(32'h0, 1'b0, 0, 32'h0);
        start_dump(32'h0);
        wait_done(edges);
        check("full_cycles", 64'(edges), 64'(65));
        @(negedge clk);
        check("full_busy_after", 64'(busy), 64'(0));
        check("full_done_pulse", 64'(done), 64'(0));
        check("full_beats", 64'(beat_cnt - b0), 64'(32));
        check("full_done_cnt", 64'(done_cnt - d0), 64'(1));
        check("full_queue_empty", 64'(exp_q.size()), 64'(0));

        // Sparse mask with back-pressure.
        ready_mode = 1;
        b0 = beat_cnt;
        push_expected(~32'h0201_0100, 1'b0, 0, 32'h0);
        start_dump(~32'h0201_0100);
        wait_done(edges);
        @(negedge clk);
        check("sparse_beats", 64'(beat_cnt - b0), 64'(3));
        check("sparse_queue_empty", 64'(exp_q.size()), 64'(0));

        // All masked.
        ready_mode = 0;
        b0 = beat_cnt;
        start_dump(32'hFFFF_FFFF);
        wait_done(edges);
        check("allmask_cycles", 64'(edges), 64'(33));
        @(negedge clk);
        check("allmask_busy_after", 64'(busy), 64'(0));
        check("allmask_beats", 64'(beat_cnt - b0), 64'(0));

        // Start while busy is ignored.
        d0 = done_cnt;
        b0 = beat_cnt;
        push_expected(32'h0, 1'b0, 0, 32'h0);
        start_dump(32'h0);
        repeat (10) @(posedge clk);
        #1;
        start     = 1'b1;
        skip_mask = 32'hFFFF_0000;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(edges);
        repeat (6) @(negedge clk);
        check("busy_start_done_cnt", 64'(done_cnt - d0), 64'(1));
        check("busy_start_beats", 64'(beat_cnt - b0), 64'(32));
        check("busy_start_idle", 64'(busy), 64'(0));

        // Reset mid-dump while stalled on addr 5.
        ready_mode = 2;
        start_dump(32'h0000_001F);
        edges = 0;
        while (!dump_valid && edges < 100) begin
            @(negedge clk);
            edges++;
        end
        check("rstmid_valid", 64'(dump_valid), 64'(1));
        check("rstmid_addr", 64'(dump_addr), 64'(5));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rstmid_valid_after", 64'(dump_valid), 64'(0));
        check("rstmid_busy_after", 64'(busy), 64'(0));
        check("rstmid_last_after", 64'(dump_last), 64'(0));
        check("rstmid_addr_after", 64'(dump_addr), 64'(0));
        rst_n      = 1'b1;
        ready_mode = 0;
        push_expected(32'h0, 1'b0, 0, 32'h0);
        start_dump(32'h0);
        check("restart_rfaddr", 64'(rf_read_addr), 64'(0));
        check("restart_busy", 64'(busy), 64'(1));
        wait_done(edges);
        check("restart_cycles", 64'(edges), 64'(65));

        // Register-file write before the scan reaches reg 20.
        @(negedge clk);
        push_expected(32'h0, 1'b1, 20, 32'hDEAD_BEEF);
        start_dump(32'h0);
        check("lat_valid_before", 64'(dump_valid), 64'(0));
        @(posedge clk);
        #1;
        check("lat_valid", 64'(dump_valid), 64'(1));
        check("lat_addr", 64'(dump_addr), 64'(0));
        repeat (10) @(posedge clk);
        @(negedge clk);
        rf[20] = 32'hDEAD_BEEF;
        wait_done(edges);
        @(negedge clk);
        check("write_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
